// File: rtl/dec576_pipe_if.sv
// Handshake bundle for the 576-bit index-to-mask decoder: input index stream and output mask stream.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready carry ready-side flow control in each direction.
interface dec576_pipe_if #(
  parameter int WID = 576
) ();
  logic           in_valid;
  logic           in_ready;
  logic [9:0]     in_idx;
  logic           in_thermo;
  logic           out_valid;
  logic           out_ready;
  logic [WID-1:0] out_o;
  logic           out_err;

  // Decoder side: consumes indices, produces masks.
  modport slave (
    input  in_valid, in_idx, in_thermo, out_ready,
    output in_ready, out_valid, out_o, out_err
  );

  // Producer/consumer side: drives indices, takes masks.
  modport master (
    output in_valid, in_idx, in_thermo, out_ready,
    input  in_ready, out_valid, out_o, out_err
  );
endinterface

// File: rtl/dec576_pipe.sv
// Decodes a 10-bit bit index into a WID-bit one-hot or thermometer mask (inverse of find-last-one).
// Latency: 2 clocks from accepted input to out_valid; one index per clock sustained.
// Backpressure: in_ready = ~s1_v | ~s2_v | out_ready, combinational from out_ready, no skid buffer.
module dec576_pipe #(
  parameter int WID  = 576,
  parameter int SEG  = 144,
  parameter int NONE = 1023
) (
  input  logic          clk,
  input  logic          rst,
  dec576_pipe_if.slave  io
);

  localparam int IW   = 10;
  localparam int NSEG = WID / SEG;
  localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int OFFW = (SEG > 1) ? $clog2(SEG) : 1;

  // Stage 1 state: segment/offset split of the index plus classification flags.
  logic            s1_v_q, s1_v_d;
  logic [SEGW-1:0] s1_seg_q, s1_seg_d;
  logic [OFFW-1:0] s1_off_q, s1_off_d;
  logic            s1_thermo_q, s1_thermo_d;
  logic            s1_none_q, s1_none_d;
  logic            s1_err_q, s1_err_d;

  // Stage 2 state: the registered output beat.
  logic            s2_v_q, s2_v_d;
  logic [WID-1:0]  out_o_q, out_o_d;
  logic            out_err_q, out_err_d;

  logic            adv1, adv2;
  logic [SEGW-1:0] in_seg;
  logic [IW-1:0]   in_base;
  logic [OFFW-1:0] in_off;
  logic [WID-1:0]  mask;

  // A stage may load when it is empty or its contents are leaving this cycle.
  assign adv2 = ~s2_v_q | io.out_ready;
  assign adv1 = ~s1_v_q | adv2;

  assign io.in_ready  = adv1;
  assign io.out_valid = s2_v_q;
  assign io.out_o     = out_o_q;
  assign io.out_err   = out_err_q;

  // Split the index into segment and offset with a compare chain on segment boundaries instead of a divider.
  always_comb begin
    in_seg  = '0;
    in_base = '0;
    for (int j = 1; j < NSEG; j++) begin
      if (io.in_idx >= IW'(j * SEG)) begin
        in_seg  = SEGW'(j);
        in_base = IW'(j * SEG);
      end
    end
    // Offset is meaningless for illegal/none codes; those beats are zeroed in stage 2.
    in_off = OFFW'(io.in_idx - in_base);
  end

  // Stage 1 next state: capture a new beat (or bubble) whenever stage 1 advances.
  always_comb begin
    s1_v_d      = s1_v_q;
    s1_seg_d    = s1_seg_q;
    s1_off_d    = s1_off_q;
    s1_thermo_d = s1_thermo_q;
    s1_none_d   = s1_none_q;
    s1_err_d    = s1_err_q;
    if (adv1) begin
      s1_v_d      = io.in_valid;
      s1_seg_d    = in_seg;
      s1_off_d    = in_off;
      s1_thermo_d = io.in_thermo;
      s1_none_d   = (io.in_idx == IW'(NONE));
      s1_err_d    = (io.in_idx >= IW'(WID)) && (io.in_idx != IW'(NONE));
    end
  end

  // Expand within segments: segments below seg are full (thermo), segment seg gets the local one-hot/thermo pattern.
  always_comb begin
    mask = '0;
    for (int j = 0; j < NSEG; j++) begin
      for (int k = 0; k < SEG; k++) begin
        if (s1_thermo_q) begin
          mask[j*SEG+k] = (SEGW'(j) < s1_seg_q) ||
                          ((SEGW'(j) == s1_seg_q) && (OFFW'(k) <= s1_off_q));
        end else begin
          mask[j*SEG+k] = (SEGW'(j) == s1_seg_q) && (OFFW'(k) == s1_off_q);
        end
      end
    end
    if (s1_none_q || s1_err_q) begin
      mask = '0;
    end
  end

  // Stage 2 next state: a bubble clears valid but keeps the last mask/err so a stalled output never glitches.
  always_comb begin
    s2_v_d    = s2_v_q;
    out_o_d   = out_o_q;
    out_err_d = out_err_q;
    if (adv2) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        out_o_d   = mask;
        out_err_d = s1_err_q;
      end
    end
  end

  // Pipeline registers; reset discards every in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_seg_q    <= '0;
      s1_off_q    <= '0;
      s1_thermo_q <= 1'b0;
      s1_none_q   <= 1'b0;
      s1_err_q    <= 1'b0;
      s2_v_q      <= 1'b0;
      out_o_q     <= '0;
      out_err_q   <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_seg_q    <= s1_seg_d;
      s1_off_q    <= s1_off_d;
      s1_thermo_q <= s1_thermo_d;
      s1_none_q   <= s1_none_d;
      s1_err_q    <= s1_err_d;
      s2_v_q      <= s2_v_d;
      out_o_q     <= out_o_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_dec576_pipe.sv
// Directed bench for dec576_pipe: reset, latency, boundaries, none/illegal codes, stall, mid-flight reset, round trip.
// Latency: checks the 2-clock input-to-output delay directly.
// Backpressure: exercises out_ready stalls and the resulting in_ready drop.
module tb_dec576_pipe;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  dec576_pipe_if #(.WID(576)) io ();

  dec576_pipe #(.WID(576), .SEG(144), .NONE(1023)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  // Reference find-last-one encoder: highest set bit, 1023 when empty.
  function automatic logic [9:0] flo576(input logic [575:0] v);
    logic [9:0] r;
    r = 10'd1023;
    for (int i = 0; i < 576; i++) begin
      if (v[i]) r = 10'(i);
    end
    return r;
  endfunction

  // Push one index through an empty pipeline with out_ready high; report valid after 1 and 2 clocks.
  task automatic run_one(input logic [9:0] idx, input logic th,
                         output logic v1, output logic v2,
                         output logic [575:0] o, output logic e);
    io.in_valid  = 1'b1;
    io.in_idx    = idx;
    io.in_thermo = th;
    io.out_ready = 1'b1;
    @(negedge clk);
    io.in_valid = 1'b0;
    v1 = io.out_valid;
    @(negedge clk);
    v2 = io.out_valid;
    o  = io.out_o;
    e  = io.out_err;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.in_idx    = '0;
    io.in_thermo = 1'b0;
    io.out_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (io.out_valid !== 1'b0 || io.out_err !== 1'b0 || io.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ctrl: out_valid=%b out_err=%b in_ready=%b, want 0 0 1",
               io.out_valid, io.out_err, io.in_ready);
    end
    tests_run++;
    if (io.out_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_out_o: got %h, want 0", io.out_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first;
    logic v1, v2, e;
    logic [575:0] o;
    run_one(10'd0, 1'b0, v1, v2, o, e);
    tests_run++;
    if (v1 !== 1'b0 || v2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency: valid after 1clk=%b 2clk=%b, want 0 1", v1, v2);
    end
    tests_run++;
    if (o !== 576'h1 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL idx0_onehot: o=%h err=%b, want 1 err=0", o, e);
    end
  endtask

  task automatic test_boundaries;
    logic v1, v2, e;
    logic [575:0] o, exp;
    run_one(10'd0, 1'b1, v1, v2, o, e);
    tests_run++;
    if (o !== 576'h1 || v2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL idx0_thermo: o=%h valid=%b, want 1 valid=1", o, v2);
    end
    run_one(10'd575, 1'b1, v1, v2, o, e);
    exp = {576{1'b1}};
    tests_run++;
    if (o !== exp || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL idx575_thermo: o=%h err=%b, want all ones err=0", o, e);
    end
    run_one(10'd144, 1'b1, v1, v2, o, e);
    exp = {576{1'b1}} >> 431;
    tests_run++;
    if (o !== exp || $countones(o) != 145) begin
      tests_failed++;
      $display("FAIL idx144_thermo: o=%h popcount=%0d, want %h popcount=145", o, $countones(o), exp);
    end
    run_one(10'd143, 1'b1, v1, v2, o, e);
    exp = {576{1'b1}} >> 432;
    tests_run++;
    if (o !== exp) begin
      tests_failed++;
      $display("FAIL idx143_thermo: o=%h, want %h", o, exp);
    end
    run_one(10'd143, 1'b0, v1, v2, o, e);
    exp = '0;
    exp[143] = 1'b1;
    tests_run++;
    if (o !== exp) begin
      tests_failed++;
      $display("FAIL idx143_onehot: o=%h, want %h", o, exp);
    end
    run_one(10'd144, 1'b0, v1, v2, o, e);
    exp = '0;
    exp[144] = 1'b1;
    tests_run++;
    if (o !== exp) begin
      tests_failed++;
      $display("FAIL idx144_onehot: o=%h, want %h", o, exp);
    end
    run_one(10'd500, 1'b1, v1, v2, o, e);
    exp = {576{1'b1}} >> 75;
    tests_run++;
    if (o !== exp) begin
      tests_failed++;
      $display("FAIL idx500_thermo: o=%h, want %h", o, exp);
    end
  endtask

  task automatic test_none_err;
    logic v1, v2, e;
    logic [575:0] o, exp;
    run_one(10'd1023, 1'b1, v1, v2, o, e);
    tests_run++;
    if (v2 !== 1'b1 || o !== '0 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL none: valid=%b o=%h err=%b, want 1 0 0", v2, o, e);
    end
    run_one(10'd600, 1'b0, v1, v2, o, e);
    tests_run++;
    if (v2 !== 1'b1 || o !== '0 || e !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal600: valid=%b o=%h err=%b, want 1 0 1", v2, o, e);
    end
    run_one(10'd5, 1'b0, v1, v2, o, e);
    exp = '0;
    exp[5] = 1'b1;
    tests_run++;
    if (v2 !== 1'b1 || o !== exp || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_illegal: valid=%b o=%h err=%b, want 1 %h 0", v2, o, e, exp);
    end
    run_one(10'd576, 1'b1, v1, v2, o, e);
    tests_run++;
    if (o !== '0 || e !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal576: o=%h err=%b, want 0 1", o, e);
    end
    run_one(10'd1022, 1'b1, v1, v2, o, e);
    tests_run++;
    if (o !== '0 || e !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal1022: o=%h err=%b, want 0 1", o, e);
    end
  endtask

  // Indices 10..13 streamed while the consumer stalls for four cycles after the second accept.
  task automatic test_back_to_back;
    int sent = 0;
    int got  = 0;
    logic [575:0] exp;
    for (int c = 0; c < 30; c++) begin
      io.out_ready = !(c >= 2 && c <= 5);
      io.in_valid  = (sent < 4);
      io.in_idx    = 10'(10 + sent);
      io.in_thermo = 1'b0;
      #1;
      if (c == 2) begin
        tests_run++;
        if (sent != 2) begin
          tests_failed++;
          $display("FAIL b2b_accepts_before_drop: got %0d, want 2", sent);
        end
      end
      if (c >= 2 && c <= 5) begin
        exp = '0;
        exp[10] = 1'b1;
        tests_run++;
        if (io.in_ready !== 1'b0 || io.out_valid !== 1'b1 || io.out_o !== exp) begin
          tests_failed++;
          $display("FAIL b2b_stall_c%0d: in_ready=%b out_valid=%b o=%h, want 0 1 %h",
                   c, io.in_ready, io.out_valid, io.out_o, exp);
        end
      end
      if (io.in_valid && io.in_ready) sent++;
      if (io.out_valid && io.out_ready) begin
        if (got < 4) begin
          exp = '0;
          exp[10+got] = 1'b1;
          tests_run++;
          if (io.out_o !== exp || io.out_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_order_%0d: o=%h, want %h", got, io.out_o, exp);
          end
        end
        got++;
      end
      @(negedge clk);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    tests_run++;
    if (sent != 4 || got != 4) begin
      tests_failed++;
      $display("FAIL b2b_count: sent=%0d delivered=%0d, want 4 4", sent, got);
    end
  endtask

  task automatic test_reset_mid;
    io.out_ready = 1'b0;
    io.in_valid  = 1'b1;
    io.in_idx    = 10'd7;
    io.in_thermo = 1'b1;
    @(negedge clk);
    io.in_idx    = 10'd600;
    io.in_thermo = 1'b0;
    @(negedge clk);
    io.in_valid = 1'b0;
    tests_run++;
    if (io.out_valid !== 1'b1 || io.out_o !== 576'hff) begin
      tests_failed++;
      $display("FAIL rstmid_pre: out_valid=%b o=%h, want 1 ff", io.out_valid, io.out_o);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (io.out_valid !== 1'b0 || io.out_o !== '0 || io.out_err !== 1'b0 || io.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_async: out_valid=%b o=%h err=%b in_ready=%b, want 0 0 0 1",
               io.out_valid, io.out_o, io.out_err, io.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    io.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests_run++;
      if (io.out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_stale_c%0d: out_valid=%b, want 0", c, io.out_valid);
      end
    end
  endtask

  // Random legal/none indices in one-hot mode with random backpressure; encoder must return the index.
  task automatic test_roundtrip;
    logic [9:0] q[$];
    logic [9:0] cur, exp, enc;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    localparam int N = 60;
    cur = 10'($urandom_range(0, 575));
    while (got < N && cyc < 1000) begin
      io.in_valid  = (sent < N);
      io.in_idx    = cur;
      io.in_thermo = 1'b0;
      io.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (io.in_valid && io.in_ready) begin
        q.push_back(cur);
        sent++;
        if ($urandom_range(0, 7) == 0) cur = 10'd1023;
        else cur = 10'($urandom_range(0, 575));
      end
      if (io.out_valid && io.out_ready) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("FAIL roundtrip_extra: unexpected beat o=%h", io.out_o);
        end else begin
          exp = q.pop_front();
          enc = flo576(io.out_o);
          if (enc !== exp || io.out_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL roundtrip_%0d: encoded=%0d err=%b, want %0d err=0", got, enc, io.out_err, exp);
          end
        end
        got++;
      end
      cyc++;
      @(negedge clk);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    tests_run++;
    if (got != N) begin
      tests_failed++;
      $display("FAIL roundtrip_timeout: delivered %0d, want %0d", got, N);
    end
  endtask

  initial begin
    test_reset();
    test_first();
    test_boundaries();
    test_none_err();
    test_back_to_back();
    test_reset_mid();
    test_roundtrip();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dec576_pipe.md
Name: dec576_pipe

Overview:
- Pipelined inverse of the 576-bit find-last-one encoder: takes a 10-bit bit index and produces a 576-bit one-hot or thermometer mask.
- Used to rebuild normalisation masks and to set or clear allocator bits from an encoded index.
- Round-trip invariant: feeding the output to the find-last-one encoder returns the original index.
- Two-stage valid/ready pipeline, throughput one index per clock.

Parameters:
- WID, 576: output vector width.
- SEG, 144: segment width. Stage 1 selects the segment; stage 2 expands within it. WID must be a multiple of SEG.
- NONE, 1023: index code meaning "no bit set". Matches the encoder's all-zero result.

Ports:
- clk  input  1  clock, all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_idx and in_thermo are valid.
- in_ready  output  1  block accepts input this cycle.
- in_idx  input  10  bit index: 0..575 valid, 1023 = none, 576..1022 illegal.
- in_thermo  input  1  0 = one-hot o[idx]; 1 = thermometer o[idx:0].
- out_valid  output  1  out_o and out_err are valid.
- out_ready  input  1  downstream accepts output.
- out_o  output  576  decoded mask.
- out_err  output  1  index was illegal (576..1022).

Behaviour:
- Reset (async assert, sync release): s1_v=0, s2_v=0, out_valid=0, out_o=0, out_err=0, in_ready=1.
- Transfer rule: a transfer occurs when valid & ready are both high at the clock edge.
- Stage 2 advance: adv2 = ~s2_v | out_ready.
- Stage 1 advance: adv1 = ~s1_v | adv2.
- in_ready = adv1. It is combinational from out_ready; no skid buffer.
- Stage 1 (on adv1): captures v=in_valid, seg = idx/SEG (0..3), off = idx%SEG (0..143), thermo, none = (idx==NONE), err = (576<=idx<=1022).
  - The divide is a compare chain against 144, 288, 432. No true divider.
- Stage 2 (on adv2): captures v=s1_v and err=s1_err.
  - If none or err: o = 0.
  - One-hot: o = single bit at seg*SEG+off.
  - Thermo: every segment below seg is all ones; segment seg has bits off..0 set; segments above are 0.
  - A bubble (s1_v=0) loads s2_v=0 and leaves out_o unchanged.
- Latency: 2 clocks from accepted input to out_valid with no stall. Sustained 1/clk when out_ready is held high.
- Stall: while out_valid & ~out_ready, out_o and out_err hold stable. Stage 1 stays filled; in_ready deasserts only when both stages are full.
- Boundaries:
  - idx=0 one-hot and thermo both give o=1.
  - idx=575 thermo gives all ones.
  - idx=143/144 cross a segment edge correctly.
  - idx=NONE gives o=0 with err=0.
  - Illegal idx gives o=0 with err=1 and is still consumed and delivered. No pipeline stall, no sticky state.
- Simultaneous events: accept, stage 1 to stage 2 move and output consume in one cycle are all legal. No entry is dropped or duplicated.
- Reset mid-operation: all in-flight entries are discarded. Nothing appears after release until new input is accepted.
- Widths: seg*SEG+off computed in 10 bits; no overflow for legal idx.

Test Plan:
- Reset then idx=0, thermo=0, out_ready=1 -> exactly 2 clocks later out_valid=1, out_o=576'h1, out_err=0.
- idx=575, thermo=1 -> out_o all ones. idx=144, thermo=1 -> out_o[144:0] all ones, out_o[575:145]=0 (popcount 145).
- idx=1023 -> out_o=0, out_err=0. idx=600 -> out_o=0, out_err=1. The next input idx=5 one-hot gives out_o=1<<5, out_err=0.
- Back-to-back idx 10, 11, 12, 13 with out_ready low for cycles 3-6:
  - in_ready drops after 2 accepts.
  - out_o holds 1<<10 through the stall.
  - Outputs then appear in order 10, 11, 12, 13 with no loss or duplication.
- Assert rst while 2 entries are in flight -> out_valid=0 immediately (async), out_o=0. After release, no stale output appears.
- Random legal idx plus NONE, one-hot mode, output fed to flo576 -> encoder result equals the input idx on every beat (NONE -> 1023).
